// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// The result is captured with the winner's ID in a one-entry valid/ready response register.
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [5:0]        r0_func,
    input  logic [1:0]        r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    output logic              r0_gnt,
    input  logic              r1_req,
    input  logic [5:0]        r1_func,
    input  logic [1:0]        r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_function,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready
);

    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              last_id_reg;

    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    logic [5:0]        func_arr [2];
    logic [1:0]        op_arr   [2];
    logic [DATA_W-1:0] a_arr    [2];
    logic [DATA_W-1:0] b_arr    [2];
    logic              can_issue;

    assign req_vec  = {r1_req, r0_req};
    assign func_arr = '{r0_func, r1_func};
    assign op_arr   = '{r0_op, r1_op};
    assign a_arr    = '{r0_a, r1_a};
    assign b_arr    = '{r0_b, r1_b};

    // Reset gating keeps grants and ALU drive quiet while reset is held.
    assign can_issue = !reset && (!rsp_valid_reg || rsp_ready);

    // A requester wins when alone, or on a tie when it was not the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign gnt_vec[gi] = can_issue && req_vec[gi] &&
                                 (!req_vec[1-gi] || (last_id_reg != 1'(gi)));
        end
    endgenerate

    assign r0_gnt = gnt_vec[0];
    assign r1_gnt = gnt_vec[1];

    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_function = '0;
        alu_op       = '0;
        for (int i = 0; i < 2; i++) begin
            if (gnt_vec[i]) begin
                alu_a        = a_arr[i];
                alu_b        = b_arr[i];
                alu_function = func_arr[i];
                alu_op       = op_arr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_data_reg  <= '0;
            last_id_reg   <= 1'b1;
        end else if (|gnt_vec) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= gnt_vec[1];
            rsp_data_reg  <= alu_result;
            last_id_reg   <= gnt_vec[1];
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed test-plan steps, then randomized traffic
// compared against a round-robin transaction model.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req  [2];
    logic [5:0]   func [2];
    logic [1:0]   op   [2];
    logic [W-1:0] a    [2];
    logic [W-1:0] b    [2];
    logic         r0_gnt, r1_gnt;
    logic [W-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic [5:0]   alu_function;
    logic [1:0]   alu_op;
    logic         rsp_valid, rsp_id;
    logic         rsp_ready = 1'b0;

    int tests = 0;
    int failed = 0;

    // Reference model state
    bit           m_valid = 0;
    bit           m_id = 0;
    logic [W-1:0] m_data = '0;
    int           m_last = 1;

    always #5 clk = ~clk;

    // The shared ALU as seen by ALU control: R-type func 1 is SUB, everything else ADD.
    assign alu_result = (alu_op == 2'b10 && alu_function == 6'd1) ? alu_a - alu_b : alu_a + alu_b;

    alu_share_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .r0_req(req[0]), .r0_func(func[0]), .r0_op(op[0]), .r0_a(a[0]), .r0_b(b[0]), .r0_gnt(r0_gnt),
        .r1_req(req[1]), .r1_func(func[1]), .r1_op(op[1]), .r1_a(a[1]), .r1_b(b[1]), .r1_gnt(r1_gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_function(alu_function), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [5:0] f,
                                            input logic [W-1:0] x, input logic [W-1:0] y);
        return (o == 2'b10 && f == 6'd1) ? x - y : x + y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic r, input logic [1:0] o, input logic [5:0] f,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        req[id] = r; op[id] = o; func[id] = f; a[id] = x; b[id] = y;
    endtask

    // Called just after a falling edge with inputs already applied. Checks the
    // combinational grant/ALU drive, advances the model, then checks the
    // registered response at the next falling edge. Returns the winner or -1.
    task automatic step(input bit ready, output int win);
        logic [W-1:0] ea, eb;
        logic [5:0]   ef;
        logic [1:0]   eo;
        rsp_ready = ready;
        #1;
        win = -1;
        if (!reset && (!m_valid || ready)) begin
            // Round-robin: search starting from the requester after the last winner.
            for (int k = 1; k <= 2; k++) begin
                int id;
                id = (m_last + k) % 2;
                if (win < 0 && req[id]) win = id;
            end
        end
        ea = '0; eb = '0; ef = '0; eo = '0;
        if (win >= 0) begin
            ea = a[win]; eb = b[win]; ef = func[win]; eo = op[win];
        end
        chk("r0_gnt", r0_gnt, win == 0);
        chk("r1_gnt", r1_gnt, win == 1);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_function", alu_function, ef);
        chk("alu_op", alu_op, eo);
        if (reset) begin
            m_valid = 0; m_id = 0; m_data = '0; m_last = 1;
        end else if (win >= 0) begin
            m_valid = 1; m_id = win[0]; m_data = ref_op(eo, ef, ea, eb); m_last = win;
        end else if (ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        $display("[TB] t=%0t win=%0d ready=%0b rsp_valid=%0b rsp_id=%0b rsp_data=%0h",
                 $time, win, ready, rsp_valid, rsp_id, rsp_data);
    endtask

    initial begin
        int w;
        bit pend [2];
        for (int i = 0; i < 2; i++) set_req(i, 0, 2'b00, 6'd0, '0, '0);

        // Outputs quiet under reset
        @(negedge clk);
        step(1, w);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0;

        // Idle then first op: 5+3
        step(0, w);
        set_req(0, 1, 2'b10, 6'd0, 32'd5, 32'd3);
        step(0, w);
        chk("first_win", w, 0);
        chk("first_data", rsp_data, 32'd8);
        chk("first_id", rsp_id, 1'b0);

        // Both requesting continuously: r0 SUB 10-4, r1 op=00 7+1
        set_req(0, 1, 2'b10, 6'd1, 32'd10, 32'd4);
        set_req(1, 1, 2'b00, 6'd1, 32'd7, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1, w);
            chk("alt_win", w, (i % 2 == 0) ? 1 : 0);
            chk("alt_data", rsp_data, (i % 2 == 0) ? 32'd8 : 32'd6);
        end

        // Backpressure: r0 granted, then stall with r1 waiting
        set_req(1, 0, 2'b00, 6'd0, 32'd7, 32'd1);
        step(1, w);
        chk("bp_r0_win", w, 0);
        set_req(0, 0, 2'b10, 6'd1, 32'd10, 32'd4);
        set_req(1, 1, 2'b00, 6'd0, 32'd100, 32'd23);
        for (int i = 0; i < 3; i++) begin
            step(0, w);
            chk("bp_stall", w, -1);
            chk("bp_data_stable", rsp_data, 32'd6);
        end
        step(1, w);
        chk("bp_release_win", w, 1);
        chk("bp_release_data", rsp_data, 32'd123);

        // r1 alone again right after winning
        set_req(1, 1, 2'b10, 6'd1, 32'd9, 32'd2);
        step(1, w);
        chk("r1_again", w, 1);
        chk("r1_again_data", rsp_data, 32'd7);

        // Idle: zero ALU drive, response drains when ready
        set_req(1, 0, 2'b00, 6'd0, '0, '0);
        step(0, w);
        chk("idle_hold", rsp_valid, 1'b1);
        step(1, w);
        chk("idle_drain", rsp_valid, 1'b0);

        // Asynchronous reset with a pending response and both requesting
        set_req(0, 1, 2'b10, 6'd0, 32'd1, 32'd2);
        set_req(1, 1, 2'b10, 6'd0, 32'd3, 32'd4);
        step(0, w);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 1'b0);
        chk("arst_gnt", {r1_gnt, r0_gnt}, 2'b00);
        m_valid = 0; m_id = 0; m_data = '0; m_last = 1;
        @(negedge clk);
        step(0, w);
        reset = 1'b0;
        step(0, w);
        chk("post_reset_tie", w, 0);

        // Randomized traffic; requesters hold operands until granted
        pend[0] = 1; pend[1] = 1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 3) != 0)) begin
                    set_req(i, 1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 1)),
                            $urandom, $urandom);
                    pend[i] = 1;
                end
                req[i] = pend[i];
            end
            step($urandom_range(0, 2) != 0, w);
            if (w >= 0) pend[w] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
